// File: rtl/ysyx_23060332_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the NPC sequencing controller.
// Optional commit-trace port (macro YSYX_23060332_COMMIT_TRACE_EN) lives in the top file.
package ysyx_23060332_ctrl_pkg;

   localparam logic [31:0] ZeroWord     = 32'h0000_0000;
   localparam logic        WriteEnable  = 1'b1;
   localparam logic        JumpEnable   = 1'b1;
   localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_WAIT_I = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WAIT_M = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6
   } state_e;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/ysyx_23060332_ctrl_if.sv
// Instruction-fetch and load/store handshake bundle between the controller and memory ports.
interface ysyx_23060332_ctrl_if;

   logic        ifu_req_valid;
   logic [31:0] ifu_req_addr;
   logic        ifu_req_ready;
   logic        ifu_rsp_valid;
   logic [31:0] ifu_rsp_inst;
   logic        lsu_req_valid;
   logic        lsu_req_ready;
   logic        lsu_rsp_valid;

   modport master (
      output ifu_req_valid, ifu_req_addr, lsu_req_valid,
      input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst, lsu_req_ready, lsu_rsp_valid
   );

   modport slave (
      input  ifu_req_valid, ifu_req_addr, lsu_req_valid,
      output ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst, lsu_req_ready, lsu_rsp_valid
   );

endinterface

// File: rtl/ysyx_23060332_perf_cnt.sv
// 64-bit cycle and retired-instruction counters; both wrap silently at 2^64.
module ysyx_23060332_perf_cnt (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cnt_en,
   input  logic        ret_en,
   output logic [63:0] mcycle,
   output logic [63:0] minstret
);

   logic [63:0] r_mcycle;
   logic [63:0] r_minstret;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mcycle   <= 64'd0;
         r_minstret <= 64'd0;
      end else begin
         if (cnt_en) r_mcycle   <= r_mcycle + 64'd1;
         if (ret_en) r_minstret <= r_minstret + 64'd1;
      end
   end

   assign mcycle   = r_mcycle;
   assign minstret = r_minstret;

endmodule

// File: rtl/ysyx_23060332_ctrl.sv
// Multi-cycle NPC sequencer: owns PC/IR, drives IFU/LSU handshakes, commits each instruction once.
// Defining YSYX_23060332_COMMIT_TRACE_EN adds the commit_valid/commit_pc/commit_inst difftest port.
module ysyx_23060332_ctrl
   import ysyx_23060332_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   ysyx_23060332_ctrl_if.master        mem,
   output logic [31:0]                 inst_o,
   output logic [31:0]                 pc_o,
   input  logic                        exu_jump_en,
   input  logic [31:0]                 exu_jump_addr,
   input  logic                        exu_reg_wen,
   input  logic                        idu_is_mem,
   input  logic                        idu_is_ebreak,
   output logic                        rf_wen,
   output logic                        halted,
   output logic                        trap,
   output logic [63:0]                 mcycle,
   output logic [63:0]                 minstret
`ifdef YSYX_23060332_COMMIT_TRACE_EN
   ,
   output logic                        commit_valid,
   output logic [31:0]                 commit_pc,
   output logic [31:0]                 commit_inst
`endif
);

   state_e      r_state;
   state_e      w_next_state;
   logic [31:0] r_pc;
   logic [31:0] r_inst;
   logic        r_halted;
   logic        r_trap;
   logic        w_jump;
   logic        w_misaligned;
   logic        w_retire;
   logic [31:0] w_next_pc;

   assign w_jump       = (exu_jump_en == JumpEnable);
   assign w_misaligned = w_jump && is_misaligned(exu_jump_addr);
   assign w_retire     = (r_state == ST_WB) && !w_misaligned;
   assign w_next_pc    = w_jump ? exu_jump_addr : r_pc + 32'd4;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_FETCH;
      else        r_state <= w_next_state;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_next_state      = r_state;
      mem.ifu_req_valid = 1'b0;
      mem.lsu_req_valid = 1'b0;
      rf_wen            = 1'b0;
      unique case (r_state)
         ST_FETCH: begin
            mem.ifu_req_valid = 1'b1;
            if (mem.ifu_req_ready) w_next_state = ST_WAIT_I;
         end
         ST_WAIT_I: if (mem.ifu_rsp_valid) w_next_state = ST_EXEC;
         ST_EXEC: begin
            if (idu_is_ebreak)   w_next_state = ST_HALT;
            else if (idu_is_mem) w_next_state = ST_MEM;
            else                 w_next_state = ST_WB;
         end
         ST_MEM: begin
            mem.lsu_req_valid = 1'b1;
            if (mem.lsu_req_ready) w_next_state = ST_WAIT_M;
         end
         ST_WAIT_M: if (mem.lsu_rsp_valid) w_next_state = ST_WB;
         ST_WB: begin
            // A reset landing on WB abandons the instruction, so the write is masked too.
            rf_wen       = (exu_reg_wen == WriteEnable) && rst_n;
            w_next_state = w_misaligned ? ST_HALT : ST_FETCH;
         end
         ST_HALT: w_next_state = ST_HALT;
         default: w_next_state = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc     <= RESET_PC;
         r_inst   <= ZeroWord;
         r_halted <= 1'b0;
         r_trap   <= 1'b0;
      end else begin
         if (r_state == ST_WAIT_I && mem.ifu_rsp_valid) r_inst <= mem.ifu_rsp_inst;
         if (w_retire) r_pc <= w_next_pc;
         if (r_state == ST_EXEC && idu_is_ebreak) r_halted <= 1'b1;
         if (r_state == ST_WB && w_misaligned) r_trap <= 1'b1;
      end
   end

   assign mem.ifu_req_addr = r_pc;
   assign pc_o             = r_pc;
   assign inst_o           = r_inst;
   assign halted           = r_halted;
   assign trap             = r_trap;

   ysyx_23060332_perf_cnt u_perf_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .cnt_en   (r_state != ST_HALT),
      .ret_en   (w_retire),
      .mcycle   (mcycle),
      .minstret (minstret)
   );

`ifdef YSYX_23060332_COMMIT_TRACE_EN
   logic        r_commit_valid;
   logic [31:0] r_commit_pc;
   logic [31:0] r_commit_inst;

   // Captures the pre-update PC so difftest sees the address of the retired instruction.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_commit_valid <= 1'b0;
         r_commit_pc    <= ZeroWord;
         r_commit_inst  <= ZeroWord;
      end else begin
         r_commit_valid <= w_retire;
         if (w_retire) begin
            r_commit_pc   <= r_pc;
            r_commit_inst <= r_inst;
         end
      end
   end

   assign commit_valid = r_commit_valid;
   assign commit_pc    = r_commit_pc;
   assign commit_inst  = r_commit_inst;
`endif

endmodule

// File: tb/tb_ysyx_23060332_ctrl.sv
// Directed bench for ysyx_23060332_ctrl: fetch, stalls, jumps, LSU, ebreak, trap and reset.
module tb_ysyx_23060332_ctrl;

   logic        clk;
   logic        rst_n;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
   logic        exu_jump_en;
   logic [31:0] exu_jump_addr;
   logic        exu_reg_wen;
   logic        idu_is_mem;
   logic        idu_is_ebreak;
   logic        rf_wen;
   logic        halted;
   logic        trap;
   logic [63:0] mcycle;
   logic [63:0] minstret;

   int n_checks = 0;
   int n_fail   = 0;

   ysyx_23060332_ctrl_if bus ();

   ysyx_23060332_ctrl #(.RESET_PC(32'h8000_0000)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mem           (bus),
      .inst_o        (inst_o),
      .pc_o          (pc_o),
      .exu_jump_en   (exu_jump_en),
      .exu_jump_addr (exu_jump_addr),
      .exu_reg_wen   (exu_reg_wen),
      .idu_is_mem    (idu_is_mem),
      .idu_is_ebreak (idu_is_ebreak),
      .rf_wen        (rf_wen),
      .halted        (halted),
      .trap          (trap),
      .mcycle        (mcycle),
      .minstret      (minstret)
`ifdef YSYX_23060332_COMMIT_TRACE_EN
      ,
      .commit_valid  (),
      .commit_pc     (),
      .commit_inst   ()
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   // Drives a zero-wait fetch from inside a FETCH cycle; returns just after the edge into EXEC.
   task automatic do_fetch(input logic [31:0] inst);
      bus.ifu_req_ready = 1'b1;
      next();
      bus.ifu_req_ready = 1'b0;
      bus.ifu_rsp_valid = 1'b1;
      bus.ifu_rsp_inst  = inst;
      next();
      bus.ifu_rsp_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      next();
      next();
      settle();
      n_checks++; if (pc_o !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc_o, 32'h8000_0000); end
      n_checks++; if (inst_o !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", inst_o); end
      n_checks++; if ({halted, trap} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {halted, trap}); end
      n_checks++; if (mcycle !== 64'd0 || minstret !== 64'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", mcycle, minstret); end
      n_checks++; if (bus.ifu_req_valid !== 1'b1) begin n_fail++; $display("FAIL reset_ifu_valid: got %b want 1", bus.ifu_req_valid); end
      n_checks++; if ({rf_wen, bus.lsu_req_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b want 00", {rf_wen, bus.lsu_req_valid}); end
   endtask

   task automatic test_reset_fetch();
      rst_n = 1'b1;
      bus.ifu_req_ready = 1'b1;
      settle();
      n_checks++; if (bus.ifu_req_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL rf_addr: got %h want %h", bus.ifu_req_addr, 32'h8000_0000); end
      next();
      bus.ifu_req_ready = 1'b0;
      bus.ifu_rsp_valid = 1'b1;
      bus.ifu_rsp_inst  = 32'h0050_0093;
      settle();
      n_checks++; if (bus.ifu_req_valid !== 1'b0) begin n_fail++; $display("FAIL rf_wait_i_valid: got %b want 0", bus.ifu_req_valid); end
      n_checks++; if (mcycle !== 64'd1) begin n_fail++; $display("FAIL rf_mcycle1: got %0d want 1", mcycle); end
      next();
      bus.ifu_rsp_valid = 1'b0;
      exu_reg_wen = 1'b1;
      settle();
      n_checks++; if (inst_o !== 32'h0050_0093) begin n_fail++; $display("FAIL rf_inst: got %h want %h", inst_o, 32'h0050_0093); end
      n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL rf_exec_wen: got %b want 0", rf_wen); end
      next();
      settle();
      n_checks++; if (rf_wen !== 1'b1) begin n_fail++; $display("FAIL rf_wb_wen: got %b want 1", rf_wen); end
      n_checks++; if (pc_o !== 32'h8000_0000) begin n_fail++; $display("FAIL rf_wb_pc: got %h want %h", pc_o, 32'h8000_0000); end
      next();
      settle();
      n_checks++; if (pc_o !== 32'h8000_0004) begin n_fail++; $display("FAIL rf_next_pc: got %h want %h", pc_o, 32'h8000_0004); end
      n_checks++; if (minstret !== 64'd1) begin n_fail++; $display("FAIL rf_minstret: got %0d want 1", minstret); end
      n_checks++; if (mcycle !== 64'd4) begin n_fail++; $display("FAIL rf_mcycle4: got %0d want 4", mcycle); end
      n_checks++; if ({bus.ifu_req_valid, rf_wen} !== 2'b10) begin n_fail++; $display("FAIL rf_refetch: got %b want 10", {bus.ifu_req_valid, rf_wen}); end
   endtask

   task automatic test_fetch_stall();
      for (int i = 0; i < 3; i++) begin
         bus.ifu_req_ready = 1'b0;
         bus.ifu_rsp_valid = (i == 1);
         bus.ifu_rsp_inst  = 32'hdead_beef;
         settle();
         n_checks++; if (bus.ifu_req_valid !== 1'b1 || bus.ifu_req_addr !== 32'h8000_0004) begin n_fail++; $display("FAIL stall_hold[%0d]: got %b/%h want 1/%h", i, bus.ifu_req_valid, bus.ifu_req_addr, 32'h8000_0004); end
         n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL stall_wen[%0d]: got %b want 0", i, rf_wen); end
         next();
      end
      bus.ifu_rsp_valid = 1'b0;
      bus.ifu_req_ready = 1'b1;
      next();
      bus.ifu_req_ready = 1'b0;
      bus.ifu_rsp_valid = 1'b1;
      bus.ifu_rsp_inst  = 32'h00a0_0113;
      next();
      bus.ifu_rsp_valid = 1'b0;
      settle();
      n_checks++; if (inst_o !== 32'h00a0_0113) begin n_fail++; $display("FAIL stall_inst: got %h want %h", inst_o, 32'h00a0_0113); end
      n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL stall_exec_wen: got %b want 0", rf_wen); end
      next();
      settle();
      n_checks++; if (rf_wen !== 1'b1) begin n_fail++; $display("FAIL stall_wb_wen: got %b want 1", rf_wen); end
      next();
      settle();
      n_checks++; if (pc_o !== 32'h8000_0008 || minstret !== 64'd2) begin n_fail++; $display("FAIL stall_retire: got %h/%0d want %h/2", pc_o, minstret, 32'h8000_0008); end
   endtask

   task automatic test_jump();
      do_fetch(32'h0f80_00ef);
      exu_jump_en   = 1'b1;
      exu_jump_addr = 32'h8000_0100;
      settle();
      n_checks++; if (pc_o !== 32'h8000_0008) begin n_fail++; $display("FAIL jump_exec_pc: got %h want %h", pc_o, 32'h8000_0008); end
      next();
      settle();
      n_checks++; if (rf_wen !== 1'b1) begin n_fail++; $display("FAIL jump_wb_wen: got %b want 1", rf_wen); end
      next();
      exu_jump_en = 1'b0;
      settle();
      n_checks++; if (bus.ifu_req_valid !== 1'b1 || bus.ifu_req_addr !== 32'h8000_0100) begin n_fail++; $display("FAIL jump_target: got %b/%h want 1/%h", bus.ifu_req_valid, bus.ifu_req_addr, 32'h8000_0100); end
      n_checks++; if (minstret !== 64'd3) begin n_fail++; $display("FAIL jump_minstret: got %0d want 3", minstret); end
   endtask

   task automatic test_store_lsu_stall();
      logic [63:0] m0;
      m0 = mcycle;
      exu_reg_wen = 1'b0;
      do_fetch(32'h0020_a023);
      idu_is_mem = 1'b1;
      settle();
      n_checks++; if (bus.lsu_req_valid !== 1'b0) begin n_fail++; $display("FAIL st_exec_lsu: got %b want 0", bus.lsu_req_valid); end
      next();
      idu_is_mem = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.lsu_req_ready = (i == 2);
         settle();
         n_checks++; if (bus.lsu_req_valid !== 1'b1) begin n_fail++; $display("FAIL st_mem_valid[%0d]: got %b want 1", i, bus.lsu_req_valid); end
         next();
      end
      bus.lsu_req_ready = 1'b0;
      settle();
      n_checks++; if (bus.lsu_req_valid !== 1'b0) begin n_fail++; $display("FAIL st_wait_m_lsu: got %b want 0", bus.lsu_req_valid); end
      next();
      bus.lsu_rsp_valid = 1'b1;
      next();
      bus.lsu_rsp_valid = 1'b0;
      settle();
      n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL st_wb_wen: got %b want 0", rf_wen); end
      next();
      settle();
      n_checks++; if (mcycle - m0 !== 64'd9) begin n_fail++; $display("FAIL st_latency: got %0d want 9", mcycle - m0); end
      n_checks++; if (minstret !== 64'd4 || pc_o !== 32'h8000_0104) begin n_fail++; $display("FAIL st_retire: got %0d/%h want 4/%h", minstret, pc_o, 32'h8000_0104); end
   endtask

   task automatic test_misaligned_jump();
      logic [63:0] m_halt;
      do_fetch(32'h0000_8067);
      exu_jump_en   = 1'b1;
      exu_jump_addr = 32'h8000_0102;
      next();
      next();
      exu_jump_en       = 1'b0;
      exu_reg_wen       = 1'b1;
      bus.ifu_req_ready = 1'b1;
      settle();
      n_checks++; if ({trap, halted} !== 2'b10) begin n_fail++; $display("FAIL mis_flags: got %b want 10", {trap, halted}); end
      n_checks++; if (pc_o !== 32'h8000_0104 || minstret !== 64'd4) begin n_fail++; $display("FAIL mis_no_commit: got %h/%0d want %h/4", pc_o, minstret, 32'h8000_0104); end
      n_checks++; if ({bus.ifu_req_valid, bus.lsu_req_valid, rf_wen} !== 3'b000) begin n_fail++; $display("FAIL mis_halt_out: got %b want 000", {bus.ifu_req_valid, bus.lsu_req_valid, rf_wen}); end
      m_halt = mcycle;
      for (int i = 0; i < 3; i++) next();
      settle();
      n_checks++; if (mcycle !== m_halt) begin n_fail++; $display("FAIL mis_mcycle_freeze: got %0d want %0d", mcycle, m_halt); end
      n_checks++; if ({bus.ifu_req_valid, rf_wen, trap} !== 3'b001) begin n_fail++; $display("FAIL mis_stay_halt: got %b want 001", {bus.ifu_req_valid, rf_wen, trap}); end
      bus.ifu_req_ready = 1'b0;
      exu_reg_wen       = 1'b0;
   endtask

   task automatic test_ebreak();
      rst_n = 1'b0;
      next();
      settle();
      n_checks++; if ({trap, halted} !== 2'b00 || pc_o !== 32'h8000_0000) begin n_fail++; $display("FAIL eb_reset: got %b/%h want 00/%h", {trap, halted}, pc_o, 32'h8000_0000); end
      n_checks++; if (mcycle !== 64'd0 || minstret !== 64'd0) begin n_fail++; $display("FAIL eb_reset_cnt: got %0d/%0d want 0/0", mcycle, minstret); end
      rst_n = 1'b1;
      do_fetch(32'h0010_0073);
      idu_is_ebreak = 1'b1;
      exu_reg_wen   = 1'b1;
      settle();
      n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL eb_exec_wen: got %b want 0", rf_wen); end
      next();
      idu_is_ebreak = 1'b0;
      settle();
      n_checks++; if ({halted, trap, rf_wen, bus.ifu_req_valid} !== 4'b1000) begin n_fail++; $display("FAIL eb_halt: got %b want 1000", {halted, trap, rf_wen, bus.ifu_req_valid}); end
      n_checks++; if (minstret !== 64'd0) begin n_fail++; $display("FAIL eb_minstret: got %0d want 0", minstret); end
      next();
      settle();
      n_checks++; if ({halted, bus.ifu_req_valid} !== 2'b10) begin n_fail++; $display("FAIL eb_stay: got %b want 10", {halted, bus.ifu_req_valid}); end
      exu_reg_wen = 1'b0;
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0;
      next();
      rst_n = 1'b1;
      do_fetch(32'h0000_a103);
      idu_is_mem  = 1'b1;
      exu_reg_wen = 1'b1;
      next();
      idu_is_mem        = 1'b0;
      bus.lsu_req_ready = 1'b1;
      settle();
      n_checks++; if (bus.lsu_req_valid !== 1'b1) begin n_fail++; $display("FAIL mr_mem_valid: got %b want 1", bus.lsu_req_valid); end
      next();
      bus.lsu_req_ready = 1'b0;
      rst_n = 1'b0;
      settle();
      n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL mr_wait_m_wen: got %b want 0", rf_wen); end
      next();
      rst_n = 1'b1;
      bus.lsu_rsp_valid = 1'b1;
      settle();
      n_checks++; if (pc_o !== 32'h8000_0000 || inst_o !== 32'h0) begin n_fail++; $display("FAIL mr_regs: got %h/%h want %h/0", pc_o, inst_o, 32'h8000_0000); end
      n_checks++; if (mcycle !== 64'd0 || minstret !== 64'd0 || {halted, trap} !== 2'b00) begin n_fail++; $display("FAIL mr_state: got %0d/%0d/%b want 0/0/00", mcycle, minstret, {halted, trap}); end
      n_checks++; if ({bus.ifu_req_valid, bus.lsu_req_valid, rf_wen} !== 3'b100) begin n_fail++; $display("FAIL mr_outputs: got %b want 100", {bus.ifu_req_valid, bus.lsu_req_valid, rf_wen}); end
      next();
      settle();
      n_checks++; if ({bus.ifu_req_valid, bus.lsu_req_valid, rf_wen} !== 3'b100) begin n_fail++; $display("FAIL mr_stale_rsp: got %b want 100", {bus.ifu_req_valid, bus.lsu_req_valid, rf_wen}); end
      bus.lsu_rsp_valid = 1'b0;
      exu_reg_wen       = 1'b0;
   endtask

   initial begin
      rst_n             = 1'b0;
      exu_jump_en       = 1'b0;
      exu_jump_addr     = 32'h0;
      exu_reg_wen       = 1'b0;
      idu_is_mem        = 1'b0;
      idu_is_ebreak     = 1'b0;
      bus.ifu_req_ready = 1'b0;
      bus.ifu_rsp_valid = 1'b0;
      bus.ifu_rsp_inst  = 32'h0;
      bus.lsu_req_ready = 1'b0;
      bus.lsu_rsp_valid = 1'b0;

      test_reset();
      test_reset_fetch();
      test_fetch_stall();
      test_jump();
      test_store_lsu_stall();
      test_misaligned_jump();
      test_ebreak();
      test_reset_mid();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
